vitals_sample_scheduler: RTL and testbench

Sensor-side producer for the baby monitoring system: periodically snapshots the raw heartbeat, temperature and motion readings and presents them to the monitor core as single-cycle data/valid strobes, one channel at a time in fixed order. It sits between the sensor front-ends and the monitor's `*_data`/`*_valid` inputs. It also supports an on-demand sample request with a one-deep pending slot and overrun reporting.

---
 rtl/vitals_sample_scheduler.sv | 216 +++++++++++++++++++++
 tb/tb_vitals_sample_scheduler.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vitals_sample_scheduler.sv
// ---------------------------------------------------------------------------
// vitals_sample_scheduler
//
// Purpose:
//    This block captures the raw heartbeat, temperature and motion readings
//    at regular intervals. The capture comes from a free-running period
//    counter, or from an on-demand force request. The block then hands the
//    three values to the monitor core as one-cycle data/valid strobes, in
//    the fixed order heartbeat, temperature, motion. Strobes are separated
//    by GAP idle cycles, and a round_done pulse closes each round. One
//    request that arrives during a round is held in a pending slot. A
//    further request during that round is dropped and sets the sticky
//    overrun flag.
//
// Parameters:
//    PERIOD  enabled cycles between periodic rounds (>= 4 + 2*GAP)
//    GAP     idle cycles between consecutive strobes (0 allowed)
//    DW      sample width
//
// Ports:
//    clk                 system clock, rising edge
//    reset               asynchronous, active-low reset
//    enable              periodic sampling enable
//    force_sample        single-cycle request for an immediate round
//    hb_raw/temp_raw/motion_raw           raw sensor values
//    heartbeat_data/temperature_data/motion_data    sampled values
//    heartbeat_valid/temperature_valid/motion_valid one-cycle strobes
//    round_done          one-cycle pulse after the motion strobe
//    busy                round in progress or request pending
//    overrun             sticky: a request was dropped
// ---------------------------------------------------------------------------
module vitals_sample_scheduler #(
   parameter int PERIOD = 100,
   parameter int GAP    = 2,
   parameter int DW     = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          enable,
   input  logic          force_sample,
   input  logic [DW-1:0] hb_raw,
   input  logic [DW-1:0] temp_raw,
   input  logic [DW-1:0] motion_raw,
   output logic [DW-1:0] heartbeat_data,
   output logic [DW-1:0] temperature_data,
   output logic [DW-1:0] motion_data,
   output logic          heartbeat_valid,
   output logic          temperature_valid,
   output logic          motion_valid,
   output logic          round_done,
   output logic          busy,
   output logic          overrun
);

   localparam int            CW       = $clog2(PERIOD);
   localparam logic [CW-1:0] CNT_MAX  = CW'(PERIOD - 1);
   localparam int            GW       = (GAP > 1) ? $clog2(GAP) : 1;
   localparam logic [GW-1:0] GAP_LOAD = GW'((GAP > 0) ? GAP - 1 : 0);

   typedef enum logic [2:0] {
      IDLE,
      SEND_HB,
      GAP1,
      SEND_TEMP,
      GAP2,
      SEND_MOT,
      DONE
   } state_t;

   state_t          state_reg;
   logic [CW-1:0]   period_cnt_reg;
   logic [GW-1:0]   gap_cnt_reg;
   logic            pending_reg;
   logic            overrun_reg;
   logic [DW-1:0]   temp_shadow_reg;
   logic [DW-1:0]   mot_shadow_reg;
   logic [DW-1:0]   hb_data_reg;
   logic [DW-1:0]   temp_data_reg;
   logic [DW-1:0]   mot_data_reg;
   logic            hb_valid_reg;
   logic            temp_valid_reg;
   logic            mot_valid_reg;
   logic            round_done_reg;

   logic            tick;
   logic            request;

   // A tick and a force in the same cycle are one request.
   assign tick    = enable && (period_cnt_reg == CNT_MAX);
   assign request = tick || force_sample;

   // The period counter runs only while enabled. It snaps back to 0 when
   // disabled, so re-enabling always waits a full PERIOD.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         period_cnt_reg <= '0;
      end else if (!enable) begin
         period_cnt_reg <= '0;
      end else if (period_cnt_reg == CNT_MAX) begin
         period_cnt_reg <= '0;
      end else begin
         period_cnt_reg <= period_cnt_reg + 1'b1;
      end
   end

   // Round sequencer. Each strobe is raised on the edge that enters the
   // matching SEND state, so valid and data line up with that state. The
   // heartbeat output register also acts as the heartbeat shadow, because
   // it is loaded on the capture edge itself.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg       <= IDLE;
         gap_cnt_reg     <= '0;
         pending_reg     <= 1'b0;
         overrun_reg     <= 1'b0;
         temp_shadow_reg <= '0;
         mot_shadow_reg  <= '0;
         hb_data_reg     <= '0;
         temp_data_reg   <= '0;
         mot_data_reg    <= '0;
         hb_valid_reg    <= 1'b0;
         temp_valid_reg  <= 1'b0;
         mot_valid_reg   <= 1'b0;
         round_done_reg  <= 1'b0;
      end else begin
         hb_valid_reg   <= 1'b0;
         temp_valid_reg <= 1'b0;
         mot_valid_reg  <= 1'b0;
         round_done_reg <= 1'b0;

         case (state_reg)
            IDLE: begin
               if (request || pending_reg) begin
                  hb_data_reg     <= hb_raw;
                  temp_shadow_reg <= temp_raw;
                  mot_shadow_reg  <= motion_raw;
                  hb_valid_reg    <= 1'b1;
                  state_reg       <= SEND_HB;
                  // The pending request is served now. A new request in
                  // the same cycle takes over the slot rather than being lost.
                  pending_reg     <= pending_reg && request;
               end
            end
            SEND_HB: begin
               if (GAP == 0) begin
                  temp_data_reg  <= temp_shadow_reg;
                  temp_valid_reg <= 1'b1;
                  state_reg      <= SEND_TEMP;
               end else begin
                  gap_cnt_reg <= GAP_LOAD;
                  state_reg   <= GAP1;
               end
            end
            GAP1: begin
               if (gap_cnt_reg == '0) begin
                  temp_data_reg  <= temp_shadow_reg;
                  temp_valid_reg <= 1'b1;
                  state_reg      <= SEND_TEMP;
               end else begin
                  gap_cnt_reg <= gap_cnt_reg - 1'b1;
               end
            end
            SEND_TEMP: begin
               if (GAP == 0) begin
                  mot_data_reg  <= mot_shadow_reg;
                  mot_valid_reg <= 1'b1;
                  state_reg     <= SEND_MOT;
               end else begin
                  gap_cnt_reg <= GAP_LOAD;
                  state_reg   <= GAP2;
               end
            end
            GAP2: begin
               if (gap_cnt_reg == '0) begin
                  mot_data_reg  <= mot_shadow_reg;
                  mot_valid_reg <= 1'b1;
                  state_reg     <= SEND_MOT;
               end else begin
                  gap_cnt_reg <= gap_cnt_reg - 1'b1;
               end
            end
            SEND_MOT: begin
               round_done_reg <= 1'b1;
               state_reg      <= DONE;
            end
            DONE: begin
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase

         // During a round, the first request waits in the pending slot.
         // A second request is dropped and flagged.
         if ((state_reg != IDLE) && request) begin
            if (pending_reg) begin
               overrun_reg <= 1'b1;
            end else begin
               pending_reg <= 1'b1;
            end
         end
      end
   end

   assign heartbeat_data    = hb_data_reg;
   assign temperature_data  = temp_data_reg;
   assign motion_data       = mot_data_reg;
   assign heartbeat_valid   = hb_valid_reg;
   assign temperature_valid = temp_valid_reg;
   assign motion_valid      = mot_valid_reg;
   assign round_done        = round_done_reg;
   assign busy              = (state_reg != IDLE) || pending_reg;
   assign overrun           = overrun_reg;

endmodule

// File: tb/tb_vitals_sample_scheduler.sv
// ---------------------------------------------------------------------------
// tb_vitals_sample_scheduler
//
// Purpose:
//    Bench for vitals_sample_scheduler. It drives two instances:
//    dut_a (PERIOD=20, GAP=2) is compared every cycle against a round-offset
//    reference model, using directed sequences and random traffic.
//    dut_b (PERIOD=20, GAP=0, enable tied low) runs a vector table for the
//    forced back-to-back round.
// ---------------------------------------------------------------------------
module tb_vitals_sample_scheduler;

   localparam int P  = 20;
   localparam int G  = 2;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          reset;

   logic          enable_a, force_a;
   logic [DW-1:0] hb_a, temp_a, mot_a;
   logic [DW-1:0] a_hbd, a_td, a_md;
   logic          a_hbv, a_tv, a_mv, a_done, a_busy, a_ovr;

   logic          enable_b, force_b;
   logic [DW-1:0] hb_b, temp_b, mot_b;
   logic [DW-1:0] b_hbd, b_td, b_md;
   logic          b_hbv, b_tv, b_mv, b_done, b_busy, b_ovr;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   vitals_sample_scheduler #(.PERIOD(P), .GAP(G), .DW(DW)) dut_a (
      .clk(clk), .reset(reset), .enable(enable_a), .force_sample(force_a),
      .hb_raw(hb_a), .temp_raw(temp_a), .motion_raw(mot_a),
      .heartbeat_data(a_hbd), .temperature_data(a_td), .motion_data(a_md),
      .heartbeat_valid(a_hbv), .temperature_valid(a_tv), .motion_valid(a_mv),
      .round_done(a_done), .busy(a_busy), .overrun(a_ovr)
   );

   vitals_sample_scheduler #(.PERIOD(P), .GAP(0), .DW(DW)) dut_b (
      .clk(clk), .reset(reset), .enable(enable_b), .force_sample(force_b),
      .hb_raw(hb_b), .temp_raw(temp_b), .motion_raw(mot_b),
      .heartbeat_data(b_hbd), .temperature_data(b_td), .motion_data(b_md),
      .heartbeat_valid(b_hbv), .temperature_valid(b_tv), .motion_valid(b_mv),
      .round_done(b_done), .busy(b_busy), .overrun(b_ovr)
   );

   // ---------------- reference model for dut_a ----------------
   // Each round is identified by the index of its capture edge. Every
   // output follows from the offset of the current cycle within that round.
   int            m_e;        // index of the last clock edge
   int            m_cap;      // capture edge of the latest round
   bit            m_active;
   bit            m_pend;
   bit            m_ovr;
   int            m_pcnt;     // enabled edges modulo P
   logic [DW-1:0] m_sh_hb, m_sh_t, m_sh_m;
   logic [DW-1:0] m_hbd, m_td, m_md;
   logic [29:0]   m_exp;

   task automatic model_reset();
      m_active = 0; m_pend = 0; m_ovr = 0; m_pcnt = 0; m_cap = 0;
      m_hbd = '0; m_td = '0; m_md = '0;
      m_exp = '0;
   endtask

   task automatic model_edge();
      bit tick, req, idle_now;
      int o;
      tick = enable_a && (m_pcnt == P - 1);
      m_pcnt = enable_a ? (m_pcnt + 1) % P : 0;
      req = tick || force_a;
      // The round occupies offsets 0 .. 2G+4; offset 2G+4 is the IDLE cycle.
      idle_now = !m_active || ((m_e - m_cap) >= 2*G + 4);
      m_e++;
      if (idle_now && (req || m_pend)) begin
         m_active = 1;
         m_cap = m_e;
         m_sh_hb = hb_a; m_sh_t = temp_a; m_sh_m = mot_a;
         m_pend = m_pend && req;
      end else if (!idle_now && req) begin
         if (m_pend) m_ovr = 1;
         else m_pend = 1;
      end
      o = m_e - m_cap;
      if (m_active && o == 0)         m_hbd = m_sh_hb;
      if (m_active && o == G + 1)     m_td  = m_sh_t;
      if (m_active && o == 2*G + 2)   m_md  = m_sh_m;
      m_exp = {m_active && o == 0, m_active && o == G + 1,
               m_active && o == 2*G + 2, m_active && o == 2*G + 3,
               (m_active && o <= 2*G + 3) || m_pend, m_ovr,
               m_hbd, m_td, m_md};
   endtask

   function automatic logic [29:0] a_pack();
      return {a_hbv, a_tv, a_mv, a_done, a_busy, a_ovr, a_hbd, a_td, a_md};
   endfunction

   function automatic logic [29:0] b_pack();
      return {b_hbv, b_tv, b_mv, b_done, b_busy, b_ovr, b_hbd, b_td, b_md};
   endfunction

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp_v);
      n_cmp++;
      if (act !== exp_v) begin
         n_err++;
         $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, exp_v);
      end
   endtask

   // One clock: inputs already applied, sample #1 after the edge.
   task automatic step();
      @(posedge clk);
      #1;
      if (!reset) begin
         model_reset();
      end else begin
         model_edge();
      end
      check($sformatf("a_cycle_e%0d", m_e), {2'b0, a_pack()}, {2'b0, m_exp});
   endtask

   // Step until the selected dut_a signal is high (0=hb,1=temp,2=done).
   task automatic wait_a(input int which, input int limit);
      bit seen;
      seen = 0;
      for (int i = 0; i < limit && !seen; i++) begin
         step();
         seen = (which == 0) ? a_hbv : (which == 1) ? a_tv : a_done;
      end
      if (!seen) begin
         n_cmp++;
         n_err++;
         $display("FAIL wait_a timeout which=%0d actual=0 required=1", which);
      end
   endtask

   // ---------------- vector table for dut_b (GAP=0) ----------------
   typedef struct {
      logic          frc;
      logic [DW-1:0] r_hb, r_t, r_m;
      logic [3:0]    e_strobe;   // {hb, temp, mot, done}
      logic          e_busy;
      logic          e_ovr;
      logic [DW-1:0] e_hb, e_t, e_m;
   } vec_t;

   vec_t tbl [7];

   initial begin
      int mot_cnt;

      tbl[0] = '{1'b0, 8'd130, 8'd110, 8'd0, 4'b0000, 1'b0, 1'b0, 8'd0,   8'd0,   8'd0};
      tbl[1] = '{1'b1, 8'd130, 8'd110, 8'd0, 4'b1000, 1'b1, 1'b0, 8'd130, 8'd0,   8'd0};
      tbl[2] = '{1'b0, 8'd5,   8'd5,   8'd5, 4'b0100, 1'b1, 1'b0, 8'd130, 8'd110, 8'd0};
      tbl[3] = '{1'b0, 8'd5,   8'd5,   8'd5, 4'b0010, 1'b1, 1'b0, 8'd130, 8'd110, 8'd0};
      tbl[4] = '{1'b0, 8'd5,   8'd5,   8'd5, 4'b0001, 1'b1, 1'b0, 8'd130, 8'd110, 8'd0};
      tbl[5] = '{1'b0, 8'd5,   8'd5,   8'd5, 4'b0000, 1'b0, 1'b0, 8'd130, 8'd110, 8'd0};
      tbl[6] = '{1'b0, 8'd5,   8'd5,   8'd5, 4'b0000, 1'b0, 1'b0, 8'd130, 8'd110, 8'd0};

      reset = 1'b0;
      enable_a = 0; force_a = 0; hb_a = 0; temp_a = 0; mot_a = 0;
      enable_b = 0; force_b = 0; hb_b = 0; temp_b = 0; mot_b = 0;
      m_e = 0;
      model_reset();

      repeat (2) @(posedge clk);
      #1;
      check("reset_a", {2'b0, a_pack()}, 32'd0);
      check("reset_b", {2'b0, b_pack()}, 32'd0);

      // Periodic round on dut_a; the forced GAP=0 table runs on dut_b alongside.
      hb_a = 8'd80; temp_a = 8'd90; mot_a = 8'd1; enable_a = 1;
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 7; i++) begin
         force_b = tbl[i].frc; hb_b = tbl[i].r_hb; temp_b = tbl[i].r_t; mot_b = tbl[i].r_m;
         step();
         check($sformatf("b_vec%0d", i), {2'b0, b_pack()},
               {2'b0, tbl[i].e_strobe, tbl[i].e_busy, tbl[i].e_ovr,
                tbl[i].e_hb, tbl[i].e_t, tbl[i].e_m});
      end
      force_b = 0;
      for (int i = 7; i < 50; i++) begin
         step();
         if (m_e == 20) check("period_first_hb", {23'b0, a_hbv, a_hbd}, {23'b0, 1'b1, 8'd80});
         if (m_e == 23) check("period_first_temp", {23'b0, a_tv, a_td}, {23'b0, 1'b1, 8'd90});
         if (m_e == 26) check("period_first_mot", {23'b0, a_mv, a_md}, {23'b0, 1'b1, 8'd1});
         if (m_e == 27) check("period_first_done", {31'b0, a_done}, 32'd1);
         if (m_e == 40) check("period_second_hb", {31'b0, a_hbv}, 32'd1);
      end

      // Force during a round: the pending round uses the later raw values.
      enable_a = 0;
      repeat (12) step();
      hb_a = 8'd10; temp_a = 8'd20; mot_a = 8'd30;
      force_a = 1; step(); force_a = 0;
      wait_a(1, 20);
      force_a = 1; step(); force_a = 0;
      hb_a = 8'd70; temp_a = 8'd95; mot_a = 8'd1;
      check("force_busy", {31'b0, a_busy}, 32'd1);
      wait_a(2, 20);
      step(); step();
      check("pending_hb", {23'b0, a_hbv, a_hbd}, {23'b0, 1'b1, 8'd70});
      repeat (12) step();

      // Overrun: two requests in one round.
      force_a = 1; step(); force_a = 0;
      step();
      force_a = 1; step(); force_a = 0;
      step();
      force_a = 1; step(); force_a = 0;
      check("overrun_set", {31'b0, a_ovr}, 32'd1);
      repeat (30) step();
      check("overrun_sticky", {31'b0, a_ovr}, 32'd1);

      // enable low mid-round.
      enable_a = 1;
      wait_a(0, 40);
      enable_a = 0;
      mot_cnt = 0;
      for (int i = 0; i < 2*P; i++) begin
         step();
         if (a_mv) mot_cnt++;
      end
      check("enable_low_mot_count", mot_cnt, 32'd1);
      check("enable_low_counter", {{(32-$bits(dut_a.period_cnt_reg)){1'b0}}, dut_a.period_cnt_reg}, 32'd0);

      // Reset between the temperature and motion strobes.
      force_a = 1; step(); force_a = 0;
      step();
      force_a = 1; step(); force_a = 0;
      wait_a(1, 20);
      step();
      reset = 1'b0;
      #1;
      check("async_reset", {2'b0, a_pack()}, 32'd0);
      model_reset();
      step(); step();
      @(negedge clk);
      reset = 1'b1;
      repeat (10) step();
      check("after_reset_no_ovr", {30'b0, a_ovr, a_busy}, 32'd0);
      hb_a = 8'd44;
      force_a = 1; step(); force_a = 0;
      check("resume_hb", {23'b0, a_hbv, a_hbd}, {23'b0, 1'b1, 8'd44});

      // Random traffic against the model.
      for (int i = 0; i < 500; i++) begin
         hb_a = DW'($urandom); temp_a = DW'($urandom); mot_a = DW'($urandom);
         force_a = ($urandom_range(0, 11) == 0);
         if ($urandom_range(0, 59) == 0) enable_a = ~enable_a;
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
